// File: rtl/vjtag_pkg.sv
// vjtag_pkg: instruction codes, lengths and constants shared by the myjtag DR back end.
package vjtag_pkg;
  localparam int HASH_W_DEF = 128;
  localparam int KEY_W_DEF = 64;
  localparam int CNT_W_DEF = 32;
  localparam logic [3:0] IR_BYPASS = 4'h0;
  localparam logic [3:0] IR_WR_HASH = 4'h1;
  localparam logic [3:0] IR_WR_KEY = 4'h2;
  localparam logic [3:0] IR_WR_CTRL = 4'h3;
  localparam logic [3:0] IR_RD_STATUS = 4'h4;
  localparam logic [3:0] IR_RD_KEY = 4'h5;
  localparam logic [3:0] IR_RD_ID = 4'h6;
  localparam int LEN_HASH = 128;
  localparam int LEN_KEY = 64;
  localparam int LEN_CTRL = 8;
  localparam int LEN_STATUS = 64;
  localparam int LEN_RD_KEY = 64;
  localparam int LEN_ID = 32;
  localparam logic [31:0] ID_CODE = 32'h4D443521;
  function automatic logic is_bypass(input logic [3:0] ir);
    return !(ir inside {[IR_WR_HASH:IR_RD_ID]});
  endfunction
endpackage

// File: rtl/vjtag_dr_shift.sv
// vjtag_dr_shift: shared DR shift register and bypass bit with capture load and tdo mux.
module vjtag_dr_shift
  import vjtag_pkg::*;
#(
  parameter int HASH_W = HASH_W_DEF,
  parameter int KEY_W = KEY_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic              tck,
  input  logic              rst_n,
  input  logic              tdi,
  input  logic              cap,
  input  logic              shift,
  input  logic [3:0]        ir_cap,
  input  logic [3:0]        ir_lat,
  input  logic              core_busy,
  input  logic              core_found,
  input  logic              sticky_err,
  input  logic [KEY_W-1:0]  found_key,
  input  logic [CNT_W-1:0]  keys_tested,
  output logic [HASH_W-1:0] sr,
  output logic              tdo
);
  localparam int PAD = LEN_STATUS - 3 - CNT_W;
  logic byp;
  assign tdo = is_bypass(ir_lat) ? byp : sr[0];
  // Reads zero the upper bits; write instructions keep sr so it can be reshifted.
  always_ff @(posedge tck or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
      byp <= 1'b0;
    end else if (cap) begin
      byp <= 1'b0;
      if (ir_cap == IR_RD_STATUS) sr <= HASH_W'({core_found, core_busy, sticky_err, {PAD{1'b0}}, keys_tested});
      else if (ir_cap == IR_RD_KEY) sr <= HASH_W'(found_key);
      else if (ir_cap == IR_RD_ID) sr <= HASH_W'(ID_CODE);
    end else if (shift) begin
      sr <= {tdi, sr[HASH_W-1:1]};
      byp <= tdi;
    end
  end
endmodule

// File: rtl/vjtag_dr_handler.sv
// vjtag_dr_handler: decodes myjtag DR scans into hash/key/control writes and status/key/ID reads.
module vjtag_dr_handler
  import vjtag_pkg::*;
#(
  parameter int HASH_W = HASH_W_DEF,
  parameter int KEY_W = KEY_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic              tck,
  input  logic              rst_n,
  input  logic              tdi,
  output logic              tdo,
  input  logic [3:0]        ir_in,
  output logic [3:0]        ir_out,
  input  logic              virtual_state_cdr,
  input  logic              virtual_state_sdr,
  input  logic              virtual_state_e1dr,
  input  logic              virtual_state_pdr,
  input  logic              virtual_state_e2dr,
  input  logic              virtual_state_udr,
  input  logic              virtual_state_cir,
  input  logic              virtual_state_uir,
  output logic [HASH_W-1:0] target_hash,
  output logic              target_valid,
  output logic [KEY_W-1:0]  start_key,
  output logic              start_valid,
  output logic [7:0]        ctrl_cmd,
  output logic              ctrl_valid,
  input  logic              core_busy,
  input  logic              core_found,
  input  logic [KEY_W-1:0]  found_key,
  input  logic [CNT_W-1:0]  keys_tested
);
  logic [3:0] ir_lat;
  logic [3:0] ir_cap;
  logic [HASH_W-1:0] sr;
  logic sticky_err, is_sdr, is_udr, wr_hash, wr_key, wr_ctrl;
  logic unused_states;
  assign unused_states = &{1'b0, virtual_state_e1dr, virtual_state_pdr, virtual_state_e2dr, virtual_state_uir};
  // Capture decodes the instruction being latched on this same edge.
  assign ir_cap = virtual_state_cdr ? ir_in : ir_lat;
  assign is_sdr = virtual_state_sdr & ~virtual_state_cdr;
  assign is_udr = virtual_state_udr & ~virtual_state_sdr & ~virtual_state_cdr;
  assign wr_hash = is_udr && ir_lat == IR_WR_HASH;
  assign wr_key = is_udr && ir_lat == IR_WR_KEY;
  assign wr_ctrl = is_udr && ir_lat == IR_WR_CTRL;
  vjtag_dr_shift #(.HASH_W(HASH_W), .KEY_W(KEY_W), .CNT_W(CNT_W)) u_shift (
    .tck(tck), .rst_n(rst_n), .tdi(tdi), .cap(virtual_state_cdr), .shift(is_sdr),
    .ir_cap(ir_cap), .ir_lat(ir_lat), .core_busy(core_busy), .core_found(core_found),
    .sticky_err(sticky_err), .found_key(found_key), .keys_tested(keys_tested), .sr(sr), .tdo(tdo)
  );
  always_ff @(posedge tck or negedge rst_n) begin
    if (!rst_n) begin
      ir_lat <= IR_BYPASS;
      target_hash <= '0;
      target_valid <= 1'b0;
      start_key <= '0;
      start_valid <= 1'b0;
      ctrl_cmd <= '0;
      ctrl_valid <= 1'b0;
      sticky_err <= 1'b0;
      ir_out <= 4'b0001;
    end else begin
      target_valid <= 1'b0;
      start_valid <= 1'b0;
      ctrl_valid <= 1'b0;
      if (virtual_state_cdr) ir_lat <= ir_in;
      if ((wr_hash || wr_key) && core_busy) sticky_err <= 1'b1;
      if (wr_hash && !core_busy) begin
        target_hash <= sr[HASH_W-1 -: LEN_HASH];
        target_valid <= 1'b1;
      end
      if (wr_key && !core_busy) begin
        start_key <= sr[HASH_W-1 -: LEN_KEY];
        start_valid <= 1'b1;
      end
      if (wr_ctrl) begin
        ctrl_cmd <= sr[HASH_W-1 -: LEN_CTRL];
        ctrl_valid <= 1'b1;
        if (sr[HASH_W-1]) sticky_err <= 1'b0;
      end
      if (virtual_state_cir) ir_out <= {core_found, core_busy, sticky_err, 1'b1};
    end
  end
endmodule

// File: tb/tb_vjtag_dr_handler.sv
// tb_vjtag_dr_handler: directed DR/IR scans with a queue-based scoreboard monitor.
module tb_vjtag_dr_handler;
  localparam int K_HASH = 0, K_KEY = 1, K_CTRL = 2, K_TDO = 3, K_IROUT = 4, K_SHASH = 5, K_SKEY = 6, K_SCTRL = 7;
  localparam logic [127:0] H1 = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] H2 = 128'hFEDCBA98765432100F1E2D3C4B5A6978;
  typedef struct {
    string name;
    int kind;
    logic [127:0] v;
  } exp_t;
  exp_t q[$];
  int n_cmp = 0, n_bad = 0, rd_n = 0;
  logic tck = 0, rst_n = 0, tdi = 0, tdo;
  logic [3:0] ir_in = 0, ir_out;
  logic cdr = 0, sdr = 0, e1dr = 0, pdr = 0, e2dr = 0, udr = 0, cir = 0, uir = 0;
  logic [127:0] target_hash;
  logic [63:0] start_key, found_key = 0;
  logic [7:0] ctrl_cmd;
  logic target_valid, start_valid, ctrl_valid;
  logic core_busy = 0, core_found = 0;
  logic [31:0] keys_tested = 0;
  logic rd_scan = 0, snap_req = 0;
  logic [127:0] acc = 0;

  vjtag_dr_handler dut (
    .tck(tck), .rst_n(rst_n), .tdi(tdi), .tdo(tdo), .ir_in(ir_in), .ir_out(ir_out),
    .virtual_state_cdr(cdr), .virtual_state_sdr(sdr), .virtual_state_e1dr(e1dr),
    .virtual_state_pdr(pdr), .virtual_state_e2dr(e2dr), .virtual_state_udr(udr),
    .virtual_state_cir(cir), .virtual_state_uir(uir),
    .target_hash(target_hash), .target_valid(target_valid), .start_key(start_key),
    .start_valid(start_valid), .ctrl_cmd(ctrl_cmd), .ctrl_valid(ctrl_valid),
    .core_busy(core_busy), .core_found(core_found), .found_key(found_key), .keys_tested(keys_tested)
  );

  always #5 tck = ~tck;

  task automatic cmp(input int kind, input logic [127:0] obs);
    exp_t e;
    n_cmp++;
    if (q.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected output kind %0d value %h (nothing expected)", kind, obs);
      return;
    end
    e = q.pop_front();
    if (e.kind != kind || e.v !== obs) begin
      n_bad++;
      $display("FAIL %s: kind %0d got %h, expected kind %0d value %h", e.name, kind, obs, e.kind, e.v);
    end
  endtask

  always @(negedge tck) begin
    if (cdr) acc = '0;
    else if (sdr) acc = {tdo, acc[127:1]};
    if (target_valid) cmp(K_HASH, target_hash);
    if (start_valid) cmp(K_KEY, 128'(start_key));
    if (ctrl_valid) cmp(K_CTRL, 128'(ctrl_cmd));
    if (udr && rd_scan) cmp(K_TDO, acc >> (128 - rd_n));
    if (snap_req) begin
      if (q.size() == 0) cmp(K_IROUT, 128'(ir_out));
      else case (q[0].kind)
        K_SHASH: cmp(K_SHASH, target_hash);
        K_SKEY: cmp(K_SKEY, 128'(start_key));
        K_SCTRL: cmp(K_SCTRL, 128'(ctrl_cmd));
        default: cmp(K_IROUT, 128'(ir_out));
      endcase
    end
  end

  task automatic tick();
    @(posedge tck);
    #1;
  endtask

  task automatic expect_out(input string name, input int kind, input logic [127:0] v);
    q.push_back('{name, kind, v});
  endtask

  task automatic snap(input string name, input int kind, input logic [127:0] v);
    expect_out(name, kind, v);
    snap_req = 1;
    tick();
    snap_req = 0;
  endtask

  task automatic scan(input logic [3:0] ir, input int n, input logic [127:0] d, input logic rd,
                      input int sw_at, input logic [3:0] sw_ir);
    ir_in = ir;
    rd_scan = rd;
    rd_n = n;
    cdr = 1;
    tick();
    cdr = 0;
    for (int i = 0; i < n; i++) begin
      if (i == sw_at) ir_in = sw_ir;
      sdr = 1;
      tdi = d[i];
      tick();
    end
    sdr = 0;
    udr = 1;
    tick();
    udr = 0;
    rd_scan = 0;
    tick();
    tick();
  endtask

  task automatic ir_capture();
    cir = 1;
    tick();
    cir = 0;
    tick();
  endtask

  initial begin
    tick();
    tick();
    snap("reset_hash", K_SHASH, 128'h0);
    snap("reset_key", K_SKEY, 128'h0);
    snap("reset_ctrl", K_SCTRL, 128'h0);
    snap("reset_irout", K_IROUT, 128'h1);
    rst_n = 1;
    tick();
    expect_out("rd_id", K_TDO, 128'h4D443521);
    scan(4'h6, 32, '0, 1, -1, 0);
    expect_out("wr_hash", K_HASH, H1);
    scan(4'h1, 128, H1, 0, -1, 0);
    snap("hash_held", K_SHASH, H1);
    core_busy = 1;
    scan(4'h2, 64, 128'hDEADBEEFCAFEF00D, 0, -1, 0);
    snap("key_rejected", K_SKEY, 128'h0);
    ir_capture();
    snap("irout_sticky", K_IROUT, 128'h7);
    expect_out("wr_ctrl", K_CTRL, 128'h80);
    scan(4'h3, 8, 128'h80, 0, -1, 0);
    ir_capture();
    snap("irout_cleared", K_IROUT, 128'h5);
    core_busy = 0;
    expect_out("wr_key", K_KEY, 128'h1122334455667788);
    scan(4'h2, 64, 128'h1122334455667788, 0, -1, 0);
    keys_tested = 32'h0000_1234;
    core_found = 1;
    expect_out("rd_status", K_TDO, 128'h8000_0000_0000_1234);
    scan(4'h4, 64, '0, 1, -1, 0);
    found_key = 64'h0F1E2D3C4B5A6978;
    expect_out("rd_key", K_TDO, 128'h0F1E2D3C4B5A6978);
    scan(4'h5, 64, '0, 1, -1, 0);
    expect_out("ir_switch_hash", K_HASH, H2);
    scan(4'h1, 128, H2, 0, 64, 4'h5);
    expect_out("bypass_0", K_TDO, 128'h4B86);
    scan(4'h0, 16, 128'hA5C3, 1, -1, 0);
    expect_out("bypass_A", K_TDO, 128'h792C);
    scan(4'hA, 16, 128'h3C96, 1, -1, 0);
    ir_in = 4'h1;
    cdr = 1;
    tick();
    cdr = 0;
    for (int i = 0; i < 40; i++) begin
      sdr = 1;
      tdi = H1[i];
      tick();
    end
    sdr = 0;
    rst_n = 0;
    tick();
    snap("abort_hash", K_SHASH, 128'h0);
    snap("abort_key", K_SKEY, 128'h0);
    snap("abort_ctrl", K_SCTRL, 128'h0);
    snap("abort_irout", K_IROUT, 128'h1);
    rst_n = 1;
    tick();
    udr = 1;
    tick();
    udr = 0;
    tick();
    tick();
    snap("abort_no_commit", K_SHASH, 128'h0);
    while (q.size() != 0) begin
      exp_t e = q.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL %s: never observed, expected %h", e.name, e.v);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/vjtag_dr_handler.md
# vjtag_dr_handler

Data-register back end for the `myjtag` Virtual JTAG instance. It consumes `myjtag`'s `tck`, `tdi`, `ir_in` and `virtual_state_*` outputs and returns `tdo` and `ir_out`. It decodes host instructions to load the MD5 target hash, the start key and control commands into the brute-force core, and to read core status and the found key back. Everything runs in the `tck` domain; CDC into the core clock lives downstream.

## Interface
Parameters:
- `HASH_W`, 128: target hash width; also the shift-register length.
- `KEY_W`, 64: candidate key width.
- `CNT_W`, 32: keys-tested counter width.

Ports:
- `tck` in 1: JTAG clock from `myjtag`; the only clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `tdi` in 1: serial data in.
- `tdo` out 1: serial data out.
- `ir_in` in 4: current virtual instruction.
- `ir_out` out 4: status nibble returned on IR capture.
- `virtual_state_cdr`, `virtual_state_sdr`, `virtual_state_e1dr`, `virtual_state_pdr`, `virtual_state_e2dr`, `virtual_state_udr`, `virtual_state_cir`, `virtual_state_uir` in 1 each: TAP state flags.
- `target_hash` out HASH_W: last committed hash.
- `target_valid` out 1: one-cycle commit pulse for `target_hash`.
- `start_key` out KEY_W: last committed start key.
- `start_valid` out 1: one-cycle commit pulse for `start_key`.
- `ctrl_cmd` out 8: last committed command byte.
- `ctrl_valid` out 1: one-cycle commit pulse for `ctrl_cmd`.
- `core_busy` in 1: core status.
- `core_found` in 1: core status.
- `found_key` in KEY_W: key reported by the core.
- `keys_tested` in CNT_W: core progress count.

## Operation
- Instruction codes: 0x0 BYPASS, 0x1 WR_HASH (128 bits), 0x2 WR_KEY (64), 0x3 WR_CTRL (8), 0x4 RD_STATUS (64), 0x5 RD_KEY (64), 0x6 RD_ID (32). All other codes behave as BYPASS.
- `ir_lat`:
  - Latched from `ir_in` on every `tck` with `virtual_state_cdr`=1.
  - CDR, SDR and UDR decode use `ir_lat`, not `ir_in`. A change of `ir_in` mid-DR-scan has no effect.
- Capture, on CDR:
  - RD_STATUS: `sr[63:0]` = {`core_found`, `core_busy`, `sticky_err`, 29'b0, `keys_tested`}.
  - RD_KEY: `sr[63:0]` = `found_key`.
  - RD_ID: `sr[31:0]` = 32'h4D443521.
  - Upper `sr` bits are cleared on these reads.
  - Write instructions leave `sr` unchanged.
  - BYPASS: `byp` = 0.
- Shift, on SDR:
  - `sr` <= {`tdi`, `sr[127:1]`}.
  - `byp` <= `tdi`.
  - `tdo` = `byp` when `ir_lat` decodes to BYPASS, otherwise `sr[0]` (combinational mux).
- E1DR, PDR and E2DR: hold all state.
- Update, on UDR, with L = instruction length:
  - The written value is `sr[127 -: L]`.
  - WR_HASH: `target_hash` <= `sr[127:0]`; `target_valid` pulses.
  - WR_KEY: `start_key` <= `sr[127:64]`; `start_valid` pulses.
  - WR_CTRL: `ctrl_cmd` <= `sr[127:120]`; `ctrl_valid` pulses. If `ctrl_cmd` bit 7 is set, `sticky_err` is cleared.
- Busy rejection:
  - WR_HASH or WR_KEY committing while `core_busy`=1 is rejected.
  - Output register and strobe stay unchanged, and `sticky_err` <= 1.
  - WR_CTRL is never rejected.
- IR capture, on CIR: `ir_out` <= {`core_found`, `core_busy`, `sticky_err`, 1'b1}.
- Priority when several state flags are high at once: CDR > SDR > UDR. CIR and UIR are independent of the DR flags.

## Timing
- Posedge `tck` only.
- `*_valid` rises on the edge that samples `virtual_state_udr`=1 and falls on the next edge: width exactly 1 cycle. The data output is stable from the same edge.
- Back-to-back UDRs on consecutive cycles give two separate pulses.
- Capture data is visible on `tdo` in the cycle after the CDR sample; first SDR shift is bit 0.
- Reset values:
  - `sr`, `byp`, `ir_lat`, `target_hash`, `start_key`, `ctrl_cmd`, all `*_valid` and `sticky_err` = 0.
  - `ir_out` = 4'b0001.
- Reset asserted mid-scan aborts the scan; no strobe is issued and no output register changes.

## Structure
- `vjtag_pkg` holds:
  - instruction code localparams;
  - the ID constant 32'h4D443521;
  - `HASH_W` / `KEY_W` / `CNT_W` defaults;
  - per-instruction length constants.
- Sub-module `vjtag_dr_shift` contains:
  - the 128-bit shift register and the 1-bit bypass register;
  - the CDR parallel load, SDR shift and `tdo` mux.
- The top level contains the decode, update registers, strobes, `sticky_err` and `ir_out`.

## Test plan
- RD_ID: CDR, 32 SDR -> `tdo` sequence LSB-first equals 32'h4D443521.
- WR_HASH with `core_busy`=0: shift 128 bits of 0x0123…CDEF, then UDR -> `target_hash`=0x0123…CDEF, `target_valid` high exactly 1 cycle.
- WR_KEY with `core_busy`=1 -> `start_key` unchanged, no `start_valid`, next CIR gives `ir_out`=4'b0111. Then WR_CTRL 0x80 -> `ctrl_valid` pulses and next `ir_out`=4'b0101.
- RD_STATUS with `keys_tested`=0x0000_1234, `core_found`=1 -> 64 shifted bits = 0x8000_0000_0000_1234.
- `ir_in` switched from 0x1 to 0x5 mid-SDR -> the UDR still commits `target_hash`.
- `rst_n` low after 40 of 128 WR_HASH shifts -> all outputs at reset values and no strobe.
- BYPASS or unused code 0xA -> `tdo` equals `tdi` delayed by one SDR cycle.
